// File: rtl/sap1_control_unit.sv
// SAP-1 control core: six-state ring sequencer, instruction register and
// accumulator. The control word is decoded combinationally from the current
// ring state and the IR opcode; the W-bus mux itself lives outside.
module sap1_control_unit (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [7:0]  bus_in,
  output logic [11:0] con_word,
  output logic [3:0]  opcode,
  output logic [3:0]  ir_out,
  output logic [7:0]  ir_val,
  output logic [7:0]  acc_out,
  output logic [5:0]  t_state,
  output logic        halt
);

  // Control word bit positions, [11:0] = Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n
  localparam int B_CP   = 11;
  localparam int B_EP   = 10;
  localparam int B_LM_N = 9;
  localparam int B_CE_N = 8;
  localparam int B_LI_N = 7;
  localparam int B_EI_N = 6;
  localparam int B_LA_N = 5;
  localparam int B_EA   = 4;
  localparam int B_SU   = 3;
  localparam int B_EU   = 2;
  localparam int B_LB_N = 1;
  localparam int B_LO_N = 0;

  // Fully decoded words; the idle word has every active-low strobe high
  localparam logic [11:0] CW_IDLE      = 12'h3E3;
  localparam logic [11:0] CW_FETCH_T1  = 12'h5E3;
  localparam logic [11:0] CW_FETCH_T2  = 12'hBE3;
  localparam logic [11:0] CW_FETCH_T3  = 12'h263;
  localparam logic [11:0] CW_ADDR_T4   = 12'h1A3;
  localparam logic [11:0] CW_LDA_T5    = 12'h2C3;
  localparam logic [11:0] CW_ARITH_T5  = 12'h2E1;
  localparam logic [11:0] CW_ADD_T6    = 12'h3C7;
  localparam logic [11:0] CW_SUB_T6    = 12'h3CF;
  localparam logic [11:0] CW_OUT_T4    = 12'h3F2;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // S_HALT is a terminal state outside the ring; only CLR leaves it
  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] ir_q;
  logic [7:0] acc_q;

  assign opcode  = ir_q[7:4];
  assign ir_out  = ir_q[3:0];
  assign ir_val  = ir_q;
  assign acc_out = acc_q;
  assign halt    = (state == S_HALT);

  // Ring state register; CLR drops straight back to T1
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= S_T1;
    else      state <= state_next;
  end

  // Ring advance; HLT leaves the ring at the end of T4 and stays there
  always_comb begin
    state_next = state;
    case (state)
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3:    state_next = S_T4;
      S_T4:    state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5:    state_next = S_T6;
      S_T6:    state_next = S_T1;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_T1;
    endcase
  end

  // One-hot view of the ring for observers; all zero when halted
  always_comb begin
    t_state = 6'b000000;
    case (state)
      S_T1:    t_state = 6'b000001;
      S_T2:    t_state = 6'b000010;
      S_T3:    t_state = 6'b000100;
      S_T4:    t_state = 6'b001000;
      S_T5:    t_state = 6'b010000;
      S_T6:    t_state = 6'b100000;
      default: t_state = 6'b000000;
    endcase
  end

  // Control word decode from ring state and opcode; unknown opcodes idle
  always_comb begin
    con_word = CW_IDLE;
    case (state)
      S_T1: con_word = CW_FETCH_T1;
      S_T2: con_word = CW_FETCH_T2;
      S_T3: con_word = CW_FETCH_T3;
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: con_word = CW_ADDR_T4;
          OP_OUT:                 con_word = CW_OUT_T4;
          default:                con_word = CW_IDLE;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA:         con_word = CW_LDA_T5;
          OP_ADD, OP_SUB: con_word = CW_ARITH_T5;
          default:        con_word = CW_IDLE;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_ADD:  con_word = CW_ADD_T6;
          OP_SUB:  con_word = CW_SUB_T6;
          default: con_word = CW_IDLE;
        endcase
      end
      default: con_word = CW_IDLE;
    endcase
  end

  // IR and ACC capture the bus at the edge ending the state that strobes them low
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ir_q  <= 8'h00;
      acc_q <= 8'h00;
    end else begin
      if (!con_word[B_LI_N]) ir_q  <= bus_in;
      if (!con_word[B_LA_N]) acc_q <= bus_in;
    end
  end

  // Bits whose strobes are consumed by the PC, MAR, RAM, ALU and output register
  logic unused_bits;
  assign unused_bits = ^{con_word[B_CP], con_word[B_EP], con_word[B_LM_N],
                         con_word[B_CE_N], con_word[B_EI_N], con_word[B_EA],
                         con_word[B_SU], con_word[B_EU], con_word[B_LB_N],
                         con_word[B_LO_N]};

endmodule

// File: tb/tb_sap1_control_unit.sv
// Directed bench for sap1_control_unit: reset, fetch, every instruction class,
// halt freeze and asynchronous reset in the middle of an instruction.
module tb_sap1_control_unit;

  logic        CLK;
  logic        CLR;
  logic [7:0]  bus_in;
  logic [11:0] con_word;
  logic [3:0]  opcode;
  logic [3:0]  ir_out;
  logic [7:0]  ir_val;
  logic [7:0]  acc_out;
  logic [5:0]  t_state;
  logic        halt;

  int errors = 0;
  int checks = 0;

  sap1_control_unit dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .bus_in   (bus_in),
    .con_word (con_word),
    .opcode   (opcode),
    .ir_out   (ir_out),
    .ir_val   (ir_val),
    .acc_out  (acc_out),
    .t_state  (t_state),
    .halt     (halt)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive the three fetch states from T1, loading ir into the IR; returns in T4
  task automatic fetch(input logic [7:0] ir);
    bus_in = 8'($urandom_range(0, 255));
    step();
    bus_in = 8'($urandom_range(0, 255));
    step();
    bus_in = ir;
    step();
    bus_in = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    bus_in = 8'hFF;
    repeat (3) step();
    checks++;
    if (t_state !== 6'b000001) begin errors++; $display("FAIL reset_t_state got=%b exp=000001", t_state); end
    checks++;
    if (con_word !== 12'h5E3) begin errors++; $display("FAIL reset_con_word got=%h exp=5e3", con_word); end
    checks++;
    if ({ir_val, acc_out} !== 16'h0000) begin errors++; $display("FAIL reset_ir_acc got=%h/%h exp=00/00", ir_val, acc_out); end
    checks++;
    if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", halt); end
    #3 CLR = 1'b1;
  endtask

  task automatic test_fetch_lda();
    checks++;
    if ({t_state, con_word} !== {6'b000001, 12'h5E3}) begin errors++; $display("FAIL fetch_t1 got=%b/%h exp=000001/5e3", t_state, con_word); end
    bus_in = 8'h33;
    step();
    checks++;
    if ({t_state, con_word} !== {6'b000010, 12'hBE3}) begin errors++; $display("FAIL fetch_t2 got=%b/%h exp=000010/be3", t_state, con_word); end
    step();
    checks++;
    if ({t_state, con_word} !== {6'b000100, 12'h263}) begin errors++; $display("FAIL fetch_t3 got=%b/%h exp=000100/263", t_state, con_word); end
    checks++;
    if (ir_val !== 8'h00) begin errors++; $display("FAIL ir_before_t3_edge got=%h exp=00", ir_val); end
    bus_in = 8'h09;
    step();
    checks++;
    if ({opcode, ir_out} !== 8'h09) begin errors++; $display("FAIL lda_ir got=%h/%h exp=0/9", opcode, ir_out); end
    checks++;
    if ({t_state, con_word} !== {6'b001000, 12'h1A3}) begin errors++; $display("FAIL lda_t4 got=%b/%h exp=001000/1a3", t_state, con_word); end
    bus_in = 8'hC4;
    step();
    checks++;
    if ({t_state, con_word} !== {6'b010000, 12'h2C3}) begin errors++; $display("FAIL lda_t5 got=%b/%h exp=010000/2c3", t_state, con_word); end
    checks++;
    if (acc_out !== 8'h00) begin errors++; $display("FAIL acc_before_t5_edge got=%h exp=00", acc_out); end
    bus_in = 8'h5A;
    step();
    checks++;
    if (acc_out !== 8'h5A) begin errors++; $display("FAIL lda_acc got=%h exp=5a", acc_out); end
    checks++;
    if ({t_state, con_word} !== {6'b100000, 12'h3E3}) begin errors++; $display("FAIL lda_t6 got=%b/%h exp=100000/3e3", t_state, con_word); end
    checks++;
    if (ir_val !== 8'h09) begin errors++; $display("FAIL ir_hold got=%h exp=09", ir_val); end
    bus_in = 8'hEE;
    step();
    checks++;
    if ({t_state, acc_out} !== {6'b000001, 8'h5A}) begin errors++; $display("FAIL lda_wrap got=%b/%h exp=000001/5a", t_state, acc_out); end
  endtask

  // ADD or SUB: ir selects the op, t6_word is the expected T6 decode
  task automatic test_arith(input logic [7:0] ir, input logic [11:0] t6_word,
                            input logic [7:0] acc_prev, input logic [7:0] acc_new);
    fetch(ir);
    checks++;
    if ({ir_val, con_word} !== {ir, 12'h1A3}) begin errors++; $display("FAIL arith_t4 ir=%h got=%h/%h exp=%h/1a3", ir, ir_val, con_word, ir); end
    bus_in = 8'h99;
    step();
    checks++;
    if (con_word !== 12'h2E1) begin errors++; $display("FAIL arith_t5 ir=%h got=%h exp=2e1", ir, con_word); end
    checks++;
    if (acc_out !== acc_prev) begin errors++; $display("FAIL arith_acc_t5 ir=%h got=%h exp=%h", ir, acc_out, acc_prev); end
    step();
    checks++;
    if (con_word !== t6_word) begin errors++; $display("FAIL arith_t6 ir=%h got=%h exp=%h", ir, con_word, t6_word); end
    checks++;
    if (acc_out !== acc_prev) begin errors++; $display("FAIL arith_acc_t6 ir=%h got=%h exp=%h", ir, acc_out, acc_prev); end
    bus_in = acc_new;
    step();
    checks++;
    if ({t_state, acc_out} !== {6'b000001, acc_new}) begin errors++; $display("FAIL arith_acc ir=%h got=%b/%h exp=000001/%h", ir, t_state, acc_out, acc_new); end
  endtask

  // Instructions that never touch ACC: t4_word is the expected T4 decode
  task automatic test_passive(input logic [7:0] ir, input logic [11:0] t4_word,
                              input logic [7:0] acc_keep);
    fetch(ir);
    checks++;
    if (con_word !== t4_word) begin errors++; $display("FAIL passive_t4 ir=%h got=%h exp=%h", ir, con_word, t4_word); end
    bus_in = 8'hAA;
    step();
    checks++;
    if (con_word !== 12'h3E3) begin errors++; $display("FAIL passive_t5 ir=%h got=%h exp=3e3", ir, con_word); end
    step();
    checks++;
    if (con_word !== 12'h3E3) begin errors++; $display("FAIL passive_t6 ir=%h got=%h exp=3e3", ir, con_word); end
    step();
    checks++;
    if ({t_state, acc_out, ir_val} !== {6'b000001, acc_keep, ir}) begin errors++; $display("FAIL passive_end ir=%h got=%b/%h/%h exp=000001/%h/%h", ir, t_state, acc_out, ir_val, acc_keep, ir); end
  endtask

  task automatic test_halt(input logic [7:0] acc_keep);
    fetch(8'hF0);
    checks++;
    if ({t_state, con_word, halt} !== {6'b001000, 12'h3E3, 1'b0}) begin errors++; $display("FAIL hlt_t4 got=%b/%h/%b exp=001000/3e3/0", t_state, con_word, halt); end
    step();
    checks++;
    if ({t_state, con_word, halt} !== {6'b000000, 12'h3E3, 1'b1}) begin errors++; $display("FAIL hlt_enter got=%b/%h/%b exp=000000/3e3/1", t_state, con_word, halt); end
    for (int i = 0; i < 10; i++) begin
      bus_in = 8'($urandom_range(0, 255));
      step();
      checks++;
      if ({t_state, con_word, halt, ir_val, acc_out} !== {6'b000000, 12'h3E3, 1'b1, 8'hF0, acc_keep}) begin
        errors++;
        $display("FAIL hlt_frozen cyc=%0d got=%b/%h/%b/%h/%h exp=000000/3e3/1/f0/%h", i, t_state, con_word, halt, ir_val, acc_out, acc_keep);
      end
    end
  endtask

  // CLR pulsed between edges: clears from halt, then aborts an ADD in T5
  task automatic test_async_reset();
    #2 CLR = 1'b0;
    #1;
    checks++;
    if ({t_state, halt, con_word, ir_val, acc_out} !== {6'b000001, 1'b0, 12'h5E3, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL clr_from_halt got=%b/%b/%h/%h/%h exp=000001/0/5e3/00/00", t_state, halt, con_word, ir_val, acc_out);
    end
    #1 CLR = 1'b1;
    // Re-load ACC with LDA so the abort has something to clear
    fetch(8'h03);
    step();
    bus_in = 8'h6D;
    step();
    step();
    checks++;
    if ({t_state, acc_out} !== {6'b000001, 8'h6D}) begin errors++; $display("FAIL reload_acc got=%b/%h exp=000001/6d", t_state, acc_out); end
    fetch(8'h1B);
    step();
    checks++;
    if (t_state !== 6'b010000) begin errors++; $display("FAIL add_in_t5 got=%b exp=010000", t_state); end
    bus_in = 8'h42;
    #2 CLR = 1'b0;
    #1;
    checks++;
    if ({t_state, con_word, ir_val, acc_out} !== {6'b000001, 12'h5E3, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL clr_mid_add got=%b/%h/%h/%h exp=000001/5e3/00/00", t_state, con_word, ir_val, acc_out);
    end
    #1 CLR = 1'b1;
    step();
    checks++;
    if ({t_state, con_word} !== {6'b000010, 12'hBE3}) begin errors++; $display("FAIL refetch_t2 got=%b/%h exp=000010/be3", t_state, con_word); end
    step();
    bus_in = 8'h2C;
    step();
    checks++;
    if ({opcode, ir_out, con_word} !== {4'h2, 4'hC, 12'h1A3}) begin errors++; $display("FAIL refetch_t4 got=%h/%h/%h exp=2/c/1a3", opcode, ir_out, con_word); end
  endtask

  initial begin
    CLR = 1'b0;
    bus_in = 8'h00;
    test_reset();
    test_fetch_lda();
    test_arith(8'h1A, 12'h3C7, 8'h5A, 8'h77);
    test_arith(8'h2A, 12'h3CF, 8'h77, 8'h33);
    test_passive(8'hE0, 12'h3F2, 8'h33);
    test_passive(8'h5F, 12'h3E3, 8'h33);
    test_halt(8'h33);
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
